// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone RAM arbiter.
package wb_arb_pkg;

    localparam int DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        GAP
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: the first requester found searching upward
// from last+1 (wrapping) wins.
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    // Walk the N candidates in rotated order and keep the first live one
    always_comb begin
        logic [IW-1:0] cand;
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Round-robin arbiter sharing one single-ported Wishbone RAM slave between
// NR_MST masters, with burst lock over cyc, single-cycle slave strobes and
// a watchdog that converts a missing ack into an error.
module wb_ram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NR_MST  = 2,
    parameter int ADR_W   = 10,
    parameter int TIMEOUT = 15
) (
    input  logic                        clk_i,
    input  logic                        rst_in,
    input  logic [NR_MST-1:0]           mst_cyc_i,
    input  logic [NR_MST-1:0]           mst_stb_i,
    input  logic [NR_MST-1:0]           mst_we_i,
    input  logic [4*NR_MST-1:0]         mst_sel_i,
    input  logic [ADR_W*NR_MST-1:0]     mst_adr_i,
    input  logic [DW*NR_MST-1:0]        mst_dat_i,
    output logic [NR_MST-1:0]           mst_ack_o,
    output logic [NR_MST-1:0]           mst_err_o,
    output logic [DW-1:0]               mst_dat_o,
    output logic                        slv_cyc_o,
    output logic                        slv_stb_o,
    output logic                        slv_we_o,
    output logic [3:0]                  slv_sel_o,
    output logic [ADR_W-1:0]            slv_adr_o,
    output logic [DW-1:0]               slv_dat_o,
    input  logic                        slv_ack_i,
    input  logic [DW-1:0]               slv_dat_i,
    output logic [$clog2(NR_MST)-1:0]   gnt_o,
    output logic                        busy_o
);

    localparam int GW  = $clog2(NR_MST);
    localparam int WDW = $clog2(TIMEOUT);

    state_e          state;
    state_e          state_nxt;
    logic [GW-1:0]   gnt;
    logic [GW-1:0]   last;
    logic [WDW-1:0]  wdog;
    logic [NR_MST-1:0] req;
    logic            pick_valid;
    logic [GW-1:0]   pick_idx;
    logic            gnt_cyc;
    logic            gnt_req;
    logic            wd_expired;

    assign req        = mst_cyc_i & mst_stb_i;
    assign gnt_cyc    = mst_cyc_i[gnt];
    assign gnt_req    = req[gnt];
    assign wd_expired = (wdog == WDW'(TIMEOUT - 1));

    rr_pick #(
        .N(NR_MST)
    ) u_pick (
        .req   (req),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Read data is broadcast; only the acked master should consume it
    assign mst_dat_o = slv_dat_i;
    assign busy_o    = !rst_in && (state != IDLE);
    assign gnt_o     = rst_in ? '0 : gnt;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant, round-robin pointer and watchdog bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_in) begin
            gnt  <= '0;
            last <= GW'(NR_MST - 1);
            wdog <= '0;
        end else begin
            if (state == IDLE && pick_valid) begin
                gnt <= pick_idx;
            end
            if (state != IDLE && state_nxt == IDLE) begin
                last <= gnt;
            end
            if (state == ISSUE) begin
                wdog <= '0;
            end else if (state == WAIT && !wd_expired) begin
                wdog <= wdog + WDW'(1);
            end
        end
    end

    // Next state, slave-side forwarding and master responses; all quiet in reset
    always_comb begin
        state_nxt = state;
        slv_cyc_o = 1'b0;
        slv_stb_o = 1'b0;
        slv_we_o  = 1'b0;
        slv_sel_o = '0;
        slv_adr_o = '0;
        slv_dat_o = '0;
        mst_ack_o = '0;
        mst_err_o = '0;
        if (!rst_in) begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state_nxt = ISSUE;
                    end
                end
                ISSUE: begin
                    if (!gnt_cyc) begin
                        state_nxt = IDLE;
                    end else begin
                        slv_cyc_o = 1'b1;
                        slv_stb_o = 1'b1;
                        slv_we_o  = mst_we_i[gnt];
                        slv_sel_o = mst_sel_i[4*gnt +: 4];
                        slv_adr_o = mst_adr_i[ADR_W*gnt +: ADR_W];
                        slv_dat_o = mst_dat_i[DW*gnt +: DW];
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (!gnt_cyc) begin
                        state_nxt = IDLE;
                    end else begin
                        slv_cyc_o = 1'b1;
                        slv_we_o  = mst_we_i[gnt];
                        slv_sel_o = mst_sel_i[4*gnt +: 4];
                        slv_adr_o = mst_adr_i[ADR_W*gnt +: ADR_W];
                        slv_dat_o = mst_dat_i[DW*gnt +: DW];
                        if (slv_ack_i) begin
                            mst_ack_o[gnt] = 1'b1;
                            state_nxt      = GAP;
                        end else if (wd_expired) begin
                            mst_err_o[gnt] = 1'b1;
                            state_nxt      = GAP;
                        end
                    end
                end
                GAP: begin
                    slv_cyc_o = 1'b1;
                    if (gnt_req) begin
                        state_nxt = ISSUE;
                    end else if (!gnt_cyc) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Self-checking bench for wb_ram_arbiter: a behavioural RAM slave, per-master
// expected-response queues filled at stimulus time and drained by a monitor.
module tb_wb_ram_arbiter;
    import wb_arb_pkg::*;

    localparam int NR_MST  = 2;
    localparam int ADR_W   = 10;
    localparam int TIMEOUT = 15;
    localparam int LIMIT   = 200;

    logic clk = 1'b0;
    logic rst_in;

    logic [NR_MST-1:0]       mst_cyc_i;
    logic [NR_MST-1:0]       mst_stb_i;
    logic [NR_MST-1:0]       mst_we_i;
    logic [4*NR_MST-1:0]     mst_sel_i;
    logic [ADR_W*NR_MST-1:0] mst_adr_i;
    logic [DW*NR_MST-1:0]    mst_dat_i;
    logic [NR_MST-1:0]       mst_ack_o;
    logic [NR_MST-1:0]       mst_err_o;
    logic [DW-1:0]           mst_dat_o;
    logic                    slv_cyc_o;
    logic                    slv_stb_o;
    logic                    slv_we_o;
    logic [3:0]              slv_sel_o;
    logic [ADR_W-1:0]        slv_adr_o;
    logic [DW-1:0]           slv_dat_o;
    logic                    slv_ack_i = 1'b0;
    logic [DW-1:0]           slv_dat_i = '0;
    logic [0:0]              gnt_o;
    logic                    busy_o;

    logic             cyc_a [NR_MST];
    logic             stb_a [NR_MST];
    logic             we_a  [NR_MST];
    logic [3:0]       sel_a [NR_MST];
    logic [ADR_W-1:0] adr_a [NR_MST];
    logic [31:0]      dat_a [NR_MST];

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] dat;
    } exp_t;

    exp_t        exp_q [NR_MST][$];
    int          ack_order[$];
    int          ack_cyc[$];
    logic [31:0] slv_mem [1024];
    logic [31:0] ref_mem [1024];
    int          slv_lat = 1;
    logic        ack_en = 1'b1;
    int          pend = 0;
    int          cycle = 0;
    int          stb_cyc = 0;
    logic        prev_stb = 1'b0;
    int          checks = 0;
    int          errors = 0;

    wb_ram_arbiter #(
        .NR_MST  (NR_MST),
        .ADR_W   (ADR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i     (clk),
        .rst_in    (rst_in),
        .mst_cyc_i (mst_cyc_i),
        .mst_stb_i (mst_stb_i),
        .mst_we_i  (mst_we_i),
        .mst_sel_i (mst_sel_i),
        .mst_adr_i (mst_adr_i),
        .mst_dat_i (mst_dat_i),
        .mst_ack_o (mst_ack_o),
        .mst_err_o (mst_err_o),
        .mst_dat_o (mst_dat_o),
        .slv_cyc_o (slv_cyc_o),
        .slv_stb_o (slv_stb_o),
        .slv_we_o  (slv_we_o),
        .slv_sel_o (slv_sel_o),
        .slv_adr_o (slv_adr_o),
        .slv_dat_o (slv_dat_o),
        .slv_ack_i (slv_ack_i),
        .slv_dat_i (slv_dat_i),
        .gnt_o     (gnt_o),
        .busy_o    (busy_o)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp strobes and responses
    always @(posedge clk) cycle <= cycle + 1;

    // Pack the per-master driver arrays into the DUT's flat buses
    always_comb begin
        mst_cyc_i = '0;
        mst_stb_i = '0;
        mst_we_i  = '0;
        mst_sel_i = '0;
        mst_adr_i = '0;
        mst_dat_i = '0;
        for (int m = 0; m < NR_MST; m++) begin
            mst_cyc_i[m]             = cyc_a[m];
            mst_stb_i[m]             = stb_a[m];
            mst_we_i[m]              = we_a[m];
            mst_sel_i[4*m +: 4]      = sel_a[m];
            mst_adr_i[ADR_W*m +: ADR_W] = adr_a[m];
            mst_dat_i[32*m +: 32]    = dat_a[m];
        end
    end

    // RAM slave: registered read data, byte-masked writes, ack after slv_lat cycles
    always @(posedge clk) begin
        slv_ack_i <= 1'b0;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) slv_ack_i <= ack_en;
        end
        if (slv_cyc_o && slv_stb_o) begin
            slv_dat_i <= slv_mem[slv_adr_o];
            if (slv_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (slv_sel_o[b]) slv_mem[slv_adr_o][8*b +: 8] = slv_dat_o[8*b +: 8];
                end
            end
            if (slv_lat <= 1) slv_ack_i <= ack_en;
            else pend = slv_lat - 1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: strobe must be a single-cycle pulse; every response is matched against its master's queue
    always @(negedge clk) begin : monitor
        logic [NR_MST-1:0] resp;
        int   m;
        exp_t e;
        if (rst_in) begin
            prev_stb = 1'b0;
        end else begin
            if (slv_stb_o) begin
                check_output("stb_single_pulse", 32'(prev_stb), 32'(0));
                stb_cyc = cycle;
            end
            prev_stb = slv_stb_o;
            resp = mst_ack_o | mst_err_o;
            if (resp != '0) begin
                m = -1;
                for (int k = 0; k < NR_MST; k++) if (resp[k] && m < 0) m = k;
                check_output("resp_onehot", 32'($countones(resp)), 32'(1));
                check_output("resp_is_granted", 32'(gnt_o), 32'(m));
                if (exp_q[m].size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_resp: master %0d got ack=%b err=%b, none expected", m, mst_ack_o, mst_err_o);
                end else begin
                    e = exp_q[m].pop_front();
                    check_output("resp_err_flag", 32'(mst_err_o[m]), 32'(e.err));
                    if (e.chk && !e.err) check_output("read_data", mst_dat_o, e.dat);
                end
                ack_order.push_back(m);
                ack_cyc.push_back(cycle);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_in = 1'b1;
        for (int m = 0; m < NR_MST; m++) begin
            cyc_a[m] = 1'b0;
            stb_a[m] = 1'b0;
        end
        tick();
        tick();
        rst_in = 1'b0;
        tick();
    endtask

    // One master beat: record the expected response, drive the request, wait for ack/err
    task automatic apply_stimulus(input int m, input logic we, input logic [ADR_W-1:0] adr,
                                  input logic [31:0] dat, input logic [3:0] sel, input logic keep,
                                  input logic exp_err, output int lat);
        exp_t e;
        logic done;
        e.err = exp_err;
        e.chk = !we;
        e.dat = ref_mem[adr];
        if (we && !exp_err) begin
            for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[adr][8*b +: 8] = dat[8*b +: 8];
        end
        exp_q[m].push_back(e);
        cyc_a[m] = 1'b1;
        stb_a[m] = 1'b1;
        we_a[m]  = we;
        adr_a[m] = adr;
        dat_a[m] = dat;
        sel_a[m] = sel;
        lat  = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            lat++;
            if (mst_ack_o[m] || mst_err_o[m]) begin
                done = 1'b1;
            end else if (lat >= LIMIT) begin
                checks++;
                errors++;
                $display("[TB] FAIL beat_timeout: master %0d got no response after %0d cycles, required one", m, lat);
                done = 1'b1;
            end else begin
                tick();
            end
        end
        tick();
        stb_a[m] = 1'b0;
        if (!keep) cyc_a[m] = 1'b0;
    endtask

    // Watchdog for the whole run
    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "[TB] aborted");
    end

    initial begin
        int lat0, lat1, c0;
        logic [31:0] wd;
        for (int i = 0; i < 1024; i++) begin
            slv_mem[i] = 32'(i) * 32'h9E37_79B1;
            ref_mem[i] = 32'(i) * 32'h9E37_79B1;
        end
        for (int m = 0; m < NR_MST; m++) begin
            cyc_a[m] = 1'b0; stb_a[m] = 1'b0; we_a[m] = 1'b0;
            sel_a[m] = '0;   adr_a[m] = '0;   dat_a[m] = '0;
        end
        rst_in = 1'b1;

        tick();
        @(negedge clk);
        check_output("rst_busy", 32'(busy_o), 32'(0));
        check_output("rst_slv_cyc", 32'(slv_cyc_o), 32'(0));
        check_output("rst_slv_stb", 32'(slv_stb_o), 32'(0));
        check_output("rst_ack_err", 32'({mst_ack_o, mst_err_o}), 32'(0));
        tick();
        rst_in = 1'b0;
        @(negedge clk);
        check_output("post_rst_busy", 32'(busy_o), 32'(0));
        check_output("post_rst_gnt", 32'(gnt_o), 32'(0));
        tick();

        $display("[TB] single read");
        c0 = cycle;
        apply_stimulus(0, 1'b0, 10'h005, 32'h0, 4'hF, 1'b0, 1'b0, lat0);
        check_output("t1_latency", 32'(lat0), 32'(3));
        check_output("t1_stb_cycle", 32'(stb_cyc), 32'(c0 + 1));
        check_output("t1_ack_cycle", 32'(ack_cyc[$]), 32'(c0 + 2));
        tick();
        @(negedge clk);
        check_output("t1_back_idle", 32'(busy_o), 32'(0));
        tick();

        $display("[TB] contention");
        reset_dut();
        ack_order.delete();
        ack_cyc.delete();
        fork
            begin
                for (int r = 0; r < 3; r++) begin
                    apply_stimulus(0, 1'b0, 10'(16 + r), 32'h0, 4'hF, 1'b0, 1'b0, lat0);
                    tick();
                end
            end
            begin
                for (int r = 0; r < 3; r++) begin
                    apply_stimulus(1, 1'b0, 10'(528 + r), 32'h0, 4'hF, 1'b0, 1'b0, lat1);
                    tick();
                end
            end
        join
        check_output("t2_count", 32'(ack_order.size()), 32'(6));
        for (int i = 0; i < 6 && i < ack_order.size(); i++)
            check_output("t2_rr_order", 32'(ack_order[i]), 32'(i % 2));

        $display("[TB] burst lock");
        ack_order.delete();
        ack_cyc.delete();
        fork
            begin
                for (int b = 0; b < 4; b++) begin
                    wd = $urandom;
                    apply_stimulus(1, 1'b1, 10'(512 + b), wd, 4'b0011, b < 3, 1'b0, lat1);
                    check_output("t3_beat_latency", 32'(lat1), 32'(3));
                end
            end
            begin
                tick();
                apply_stimulus(0, 1'b0, 10'h005, 32'h0, 4'hF, 1'b0, 1'b0, lat0);
            end
        join
        check_output("t3_count", 32'(ack_order.size()), 32'(5));
        for (int i = 0; i < 5 && i < ack_order.size(); i++)
            check_output("t3_order", 32'(ack_order[i]), (i < 4) ? 32'(1) : 32'(0));
        for (int i = 0; i < 3 && i + 1 < ack_cyc.size(); i++)
            check_output("t3_beat_spacing", 32'(ack_cyc[i+1] - ack_cyc[i]), 32'(3));
        tick();
        for (int b = 0; b < 4; b++) begin
            apply_stimulus(1, 1'b0, 10'(512 + b), 32'h0, 4'hF, 1'b0, 1'b0, lat1);
            tick();
        end

        $display("[TB] timeout");
        ack_en = 1'b0;
        apply_stimulus(0, 1'b0, 10'h007, 32'h0, 4'hF, 1'b0, 1'b1, lat0);
        check_output("t4_err_latency", 32'(lat0), 32'(TIMEOUT + 2));
        check_output("t4_err_after_issue", 32'(ack_cyc[$] - stb_cyc), 32'(TIMEOUT));
        @(negedge clk);
        check_output("t4_gap_busy", 32'(busy_o), 32'(1));
        tick();
        @(negedge clk);
        check_output("t4_idle_after_drop", 32'(busy_o), 32'(0));
        ack_en = 1'b1;
        tick();

        $display("[TB] abort with stale ack");
        slv_lat = 2;
        cyc_a[0] = 1'b1; stb_a[0] = 1'b1; we_a[0] = 1'b0; adr_a[0] = 10'h009; sel_a[0] = 4'hF;
        tick();
        tick();
        cyc_a[0] = 1'b0; stb_a[0] = 1'b0;
        @(negedge clk);
        check_output("t5_wait_busy", 32'(busy_o), 32'(1));
        tick();
        @(negedge clk);
        check_output("t5_idle_after_abort", 32'(busy_o), 32'(0));
        check_output("t5_stale_ack_present", 32'(slv_ack_i), 32'(1));
        check_output("t5_stale_ack_dropped", 32'(mst_ack_o), 32'(0));
        tick();
        slv_lat = 1;
        apply_stimulus(1, 1'b0, 10'h20A, 32'h0, 4'hF, 1'b0, 1'b0, lat1);
        check_output("t5_next_latency", 32'(lat1), 32'(3));
        tick();

        $display("[TB] reset in WAIT");
        apply_stimulus(0, 1'b0, 10'h00B, 32'h0, 4'hF, 1'b0, 1'b0, lat0);
        tick();
        ack_en = 1'b0;
        cyc_a[1] = 1'b1; stb_a[1] = 1'b1; we_a[1] = 1'b0; adr_a[1] = 10'h20B; sel_a[1] = 4'hF;
        tick();
        tick();
        @(negedge clk);
        check_output("t6_wait_gnt", 32'(gnt_o), 32'(1));
        tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        cyc_a[1] = 1'b0; stb_a[1] = 1'b0;
        @(negedge clk);
        check_output("t6_busy", 32'(busy_o), 32'(0));
        check_output("t6_slv_cyc_stb", 32'({slv_cyc_o, slv_stb_o}), 32'(0));
        check_output("t6_ack_err", 32'({mst_ack_o, mst_err_o}), 32'(0));
        check_output("t6_gnt", 32'(gnt_o), 32'(0));
        ack_en = 1'b1;
        tick();
        ack_order.delete();
        fork
            apply_stimulus(0, 1'b0, 10'h00C, 32'h0, 4'hF, 1'b0, 1'b0, lat0);
            apply_stimulus(1, 1'b0, 10'h20C, 32'h0, 4'hF, 1'b0, 1'b0, lat1);
        join
        check_output("t6_first_winner", 32'(ack_order.size() > 0 ? ack_order[0] : -1), 32'(0));
        tick();

        $display("[TB] random traffic");
        fork
            begin
                int lr;
                logic kp;
                for (int k = 0; k < 20; k++) begin
                    kp = (k < 19) && ($urandom_range(0, 3) == 0);
                    apply_stimulus(0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 511)),
                                   $urandom, 4'($urandom_range(1, 15)), kp, 1'b0, lr);
                    if (!kp) repeat ($urandom_range(0, 2)) tick();
                end
            end
            begin
                int lr;
                logic kp;
                for (int k = 0; k < 20; k++) begin
                    kp = (k < 19) && ($urandom_range(0, 3) == 0);
                    apply_stimulus(1, 1'($urandom_range(0, 1)), 10'($urandom_range(512, 1023)),
                                   $urandom, 4'($urandom_range(1, 15)), kp, 1'b0, lr);
                    if (!kp) repeat ($urandom_range(0, 2)) tick();
                end
            end
        join
        tick();
        check_output("q0_drained", 32'(exp_q[0].size()), 32'(0));
        check_output("q1_drained", 32'(exp_q[1].size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
